// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues one imem request per
// phase_fetch, and hands the fetched word plus its PCs to decode. Redirects
// may arrive at any time; an in-flight fetch they overtake is drained and
// dropped before refetching at the redirect target.
module instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_valid,
  output logic            stall_fetch,
  output logic            misaligned_fault
);

  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            pending_redirect, pending_n;
  logic [XLEN-1:0] pending_pc, pending_pc_n;
  logic            req_n, fv_n, fault_n;
  logic [XLEN-1:0] addr_n, curr_n, next_n;
  logic [31:0]     inst_n;
  logic [XLEN-1:0] fetch_addr, target;

  function automatic logic is_aligned(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

  // A redirect seen in IDLE takes effect on this very fetch.
  assign fetch_addr = redirect_en ? redirect_pc : pc;
  // While draining, the newest redirect target wins, even in the ack cycle.
  assign target     = redirect_en ? redirect_pc : pending_pc;

  assign stall_fetch = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and next-output logic; pulse outputs default low.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pending_n    = pending_redirect;
    pending_pc_n = pending_pc;
    req_n        = imem_req;
    addr_n       = imem_addr;
    inst_n       = inst;
    curr_n       = curr_pc_fd;
    next_n       = next_pc_fd;
    fv_n         = 1'b0;
    fault_n      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_en) pc_n = redirect_pc;
        if (phase_fetch) begin
          if (is_aligned(fetch_addr)) begin
            req_n   = 1'b1;
            addr_n  = fetch_addr;
            state_n = REQ;
          end else begin
            fault_n = 1'b1;
          end
        end
      end
      REQ: begin
        if (redirect_en) begin
          if (imem_ack) begin
            // Response for the overtaken fetch lands now: drop it and
            // retarget immediately without passing through DISCARD.
            pc_n      = redirect_pc;
            pending_n = 1'b0;
            if (is_aligned(redirect_pc)) begin
              addr_n = redirect_pc;
            end else begin
              req_n   = 1'b0;
              fault_n = 1'b1;
              state_n = IDLE;
            end
          end else begin
            pending_n    = 1'b1;
            pending_pc_n = redirect_pc;
            state_n      = DISCARD;
          end
        end else if (imem_ack) begin
          inst_n  = imem_rdata;
          curr_n  = imem_addr;
          next_n  = imem_addr + INST_BYTES;
          pc_n    = imem_addr + INST_BYTES;
          fv_n    = 1'b1;
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      DISCARD: begin
        pending_pc_n = target;
        if (imem_ack) begin
          pending_n = 1'b0;
          pc_n      = target;
          if (is_aligned(target)) begin
            addr_n  = target;
            state_n = REQ;
          end else begin
            req_n   = 1'b0;
            fault_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // PC, redirect bookkeeping, memory request and decode-facing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_VECTOR;
      pending_redirect <= 1'b0;
      pending_pc       <= '0;
      imem_req         <= 1'b0;
      imem_addr        <= '0;
      inst             <= NOP_INST;
      curr_pc_fd       <= RESET_VECTOR;
      next_pc_fd       <= RESET_VECTOR + INST_BYTES;
      fetch_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      pc               <= pc_n;
      pending_redirect <= pending_n;
      pending_pc       <= pending_pc_n;
      imem_req         <= req_n;
      imem_addr        <= addr_n;
      inst             <= inst_n;
      curr_pc_fd       <= curr_n;
      next_pc_fd       <= next_n;
      fetch_valid      <= fv_n;
      misaligned_fault <= fault_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model predicts every
// output each cycle; directed steps add literal expectations on top.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        phase_fetch;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        fetch_valid;
  logic        stall_fetch;
  logic        misaligned_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .phase_fetch      (phase_fetch),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .curr_pc_fd       (curr_pc_fd),
    .next_pc_fd       (next_pc_fd),
    .fetch_valid      (fetch_valid),
    .stall_fetch      (stall_fetch),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding fetch at most; a redirect while busy marks it
  // killed, and the kill is resolved when the memory finally answers.
  logic        e_req, e_fv, e_fault, m_kill;
  logic [31:0] e_addr, e_inst, e_curr, e_next, m_pc, m_tgt;
  logic [31:0] m_fa, m_tg;
  logic        m_kl;

  assign m_fa = redirect_en ? redirect_pc : m_pc;
  assign m_tg = redirect_en ? redirect_pc : m_tgt;
  assign m_kl = m_kill | redirect_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_req <= 0; e_addr <= 0; e_inst <= 32'h0000_0013; e_curr <= 0; e_next <= 4;
      e_fv <= 0; e_fault <= 0; m_pc <= 0; m_kill <= 0; m_tgt <= 0;
    end else begin
      e_fv    <= 0;
      e_fault <= 0;
      if (!e_req) begin
        if (redirect_en) m_pc <= redirect_pc;
        if (phase_fetch) begin
          if (m_fa[1:0] == 2'b00) begin
            e_req  <= 1;
            e_addr <= m_fa;
          end else begin
            e_fault <= 1;
          end
        end
      end else begin
        if (redirect_en) begin
          m_kill <= 1;
          m_tgt  <= redirect_pc;
        end
        if (imem_ack) begin
          if (m_kl) begin
            m_kill <= 0;
            m_pc   <= m_tg;
            if (m_tg[1:0] == 2'b00) e_addr <= m_tg;
            else begin
              e_req   <= 0;
              e_fault <= 1;
            end
          end else begin
            e_inst <= imem_rdata;
            e_curr <= e_addr;
            e_next <= e_addr + 32'd4;
            m_pc   <= e_addr + 32'd4;
            e_fv   <= 1;
            e_req  <= 0;
          end
        end
      end
    end
  end

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    chk("m_imem_req", imem_req, e_req);
    chk("m_imem_addr", imem_addr, e_addr);
    chk("m_stall", stall_fetch, e_req);
    chk("m_fetch_valid", fetch_valid, e_fv);
    chk("m_fault", misaligned_fault, e_fault);
    chk("m_inst", inst, e_inst);
    chk("m_curr_pc", curr_pc_fd, e_curr);
    chk("m_next_pc", next_pc_fd, e_next);
  end

  task automatic step(input logic pf, input logic re, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] rd);
    phase_fetch = pf; redirect_en = re; redirect_pc = rpc; imem_ack = ack; imem_rdata = rd;
    @(posedge clk); #2;
    phase_fetch = 0; redirect_en = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  initial begin
    clk = 0; rst = 1;
    phase_fetch = 0; redirect_en = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_curr", curr_pc_fd, 32'h0);
    chk("rst_next", next_pc_fd, 32'h4);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_stall", stall_fetch, 1'b0);
    rst = 0;

    // Basic fetch, ack in first REQ cycle, then sequential fetch.
    step(1, 0, 0, 0, 0);
    chk("f0_req", imem_req, 1'b1);
    chk("f0_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'h0050_0093);
    chk("f0_fv", fetch_valid, 1'b1);
    chk("f0_inst", inst, 32'h0050_0093);
    chk("f0_curr", curr_pc_fd, 32'h0);
    chk("f0_next", next_pc_fd, 32'h4);
    chk("f0_req_drop", imem_req, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("f0_fv_pulse", fetch_valid, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("f1_addr", imem_addr, 32'h4);
    step(0, 0, 0, 1, 32'h00a0_0113);
    chk("f1_curr", curr_pc_fd, 32'h4);
    chk("f1_next", next_pc_fd, 32'h8);

    // Redirect to 0x100 while fetching addr 8, ack 3 cycles later.
    step(1, 0, 0, 0, 0);
    chk("rd_addr8", imem_addr, 32'h8);
    step(0, 1, 32'h100, 0, 0);
    chk("rd_hold_addr", imem_addr, 32'h8);
    chk("rd_stall", stall_fetch, 1'b1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hdead_beef);
    chk("rd_no_fv", fetch_valid, 1'b0);
    chk("rd_req", imem_req, 1'b1);
    chk("rd_addr100", imem_addr, 32'h100);
    step(0, 0, 0, 1, 32'h0030_0193);
    chk("rd_fv", fetch_valid, 1'b1);
    chk("rd_inst", inst, 32'h0030_0193);
    chk("rd_curr", curr_pc_fd, 32'h100);
    chk("rd_next", next_pc_fd, 32'h104);

    // Ack delayed five cycles with extra phase_fetch pulses.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step((i % 2) == 0, 0, 0, 0, 0);
      chk("dl_req", imem_req, 1'b1);
      chk("dl_addr", imem_addr, 32'h104);
      chk("dl_stall", stall_fetch, 1'b1);
    end
    step(0, 0, 0, 1, 32'h0040_0213);
    chk("dl_fv", fetch_valid, 1'b1);
    chk("dl_curr", curr_pc_fd, 32'h104);
    step(0, 0, 0, 0, 0);
    chk("dl_no_queue", imem_req, 1'b0);
    chk("dl_single_fv", fetch_valid, 1'b0);

    // Redirect coincident with ack in REQ.
    step(1, 0, 0, 0, 0);
    chk("sc_addr", imem_addr, 32'h108);
    step(0, 1, 32'h200, 1, 32'h0000_0bad);
    chk("sc_no_fv", fetch_valid, 1'b0);
    chk("sc_addr200", imem_addr, 32'h200);
    step(0, 0, 0, 1, 32'h0010_0293);
    chk("sc_curr", curr_pc_fd, 32'h200);
    chk("sc_next", next_pc_fd, 32'h204);

    // Misaligned redirect in IDLE with phase_fetch.
    step(1, 1, 32'h202, 0, 0);
    chk("ma_fault", misaligned_fault, 1'b1);
    chk("ma_req", imem_req, 1'b0);
    chk("ma_curr_held", curr_pc_fd, 32'h200);
    chk("ma_inst_held", inst, 32'h0010_0293);
    step(0, 0, 0, 0, 0);
    chk("ma_pulse", misaligned_fault, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("ma_pc202", misaligned_fault, 1'b1);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("wr_idle", imem_req, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'h0000_0033);
    chk("wr_curr", curr_pc_fd, 32'hFFFF_FFFC);
    chk("wr_next", next_pc_fd, 32'h0);
    chk("wr_nofault", misaligned_fault, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("wr_addr0", imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'h0060_0313);
    chk("wr_curr0", curr_pc_fd, 32'h0);

    // Two redirects while draining: the last one wins.
    step(1, 0, 0, 0, 0);
    chk("lw_addr4", imem_addr, 32'h4);
    step(0, 1, 32'h300, 0, 0);
    step(0, 1, 32'h400, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0bad);
    chk("lw_no_fv", fetch_valid, 1'b0);
    chk("lw_addr400", imem_addr, 32'h400);
    step(0, 0, 0, 1, 32'h0070_0393);
    chk("lw_curr", curr_pc_fd, 32'h400);

    // Misaligned pending target after draining.
    step(1, 0, 0, 0, 0);
    chk("dm_addr", imem_addr, 32'h404);
    step(0, 1, 32'h302, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0bad);
    chk("dm_fault", misaligned_fault, 1'b1);
    chk("dm_req", imem_req, 1'b0);
    chk("dm_no_fv", fetch_valid, 1'b0);
    chk("dm_curr_held", curr_pc_fd, 32'h400);

    // Asynchronous reset while draining, then a stray ack.
    step(1, 1, 32'h500, 0, 0);
    chk("ar_addr500", imem_addr, 32'h500);
    step(0, 1, 32'h600, 0, 0);
    chk("ar_stall", stall_fetch, 1'b1);
    #1 rst = 1;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_stall0", stall_fetch, 1'b0);
    chk("ar_inst", inst, 32'h0000_0013);
    chk("ar_curr", curr_pc_fd, 32'h0);
    chk("ar_next", next_pc_fd, 32'h4);
    @(posedge clk); #2;
    rst = 0;
    step(0, 0, 0, 1, 32'h0000_0bad);
    chk("ar_stray_fv", fetch_valid, 1'b0);
    chk("ar_stray_inst", inst, 32'h0000_0013);
    step(1, 0, 0, 0, 0);
    chk("ar_refetch", imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'h0080_0413);
    chk("ar_inst2", inst, 32'h0080_0413);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
